// File: rtl/bram_capture_writer_pkg.sv
// Shared definitions for the capture writer and its companion word reader.
// Holds the flush FSM state encoding and the default DMA geometry so both
// directions of the RAM path agree on widths and address stride.
package bram_capture_writer_pkg;

   // Flush sequencer states: each buffered word goes out as low half, then high half.
   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_WRITE_LOW     = 2'd1,
      ST_WRITE_HIGH    = 2'd2,
      ST_WAIT_DEASSERT = 2'd3
   } flush_state_e;

   // Default DMA port geometry, common to reader and writer.
   localparam int DEF_RAM_WID       = 32;
   localparam int DEF_RAM_WORD_WID  = 16;
   localparam int DEF_RAM_WORD_INCR = 2;

endpackage

// File: rtl/bram_capture_writer_capture_buffer.sv
// Purpose: simple dual-port word store, one write port and one registered read port.
// Latency: write lands at the clock edge; read data appears one cycle after rd_addr.
// Backpressure: none, both ports accept an access every cycle.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr in, rd_dat_q registered out.
module bram_capture_writer_capture_buffer #(
   parameter int DAT_WID  = 24,
   parameter int ADDR_WID = 11,
   parameter int DEPTH    = 2048
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_WID-1:0] wr_addr,
   input  logic [DAT_WID-1:0]  wr_dat,
   input  logic [ADDR_WID-1:0] rd_addr,
   output logic [DAT_WID-1:0]  rd_dat_q
);

   // No reset on storage or read register so the array maps onto block RAM.
   logic [DAT_WID-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      rd_dat_q <= mem[rd_addr];
   end

endmodule

// File: rtl/bram_capture_writer.sv
// Purpose: capture producer words into a local buffer, then drain them to RAM as half-words.
// Latency: word_ok one cycle after word_push; each DMA half-word waits on ram_valid.
// Backpressure: push stalls while full or flushing; DMA request holds until ram_valid.
// Ports: clk/rst_L; word/word_push/word_ok/word_rst capture side; full/word_cnt status;
//        flush_start/start_addr/flush_finished user side; ram_* DMA write initiator.
module bram_capture_writer
   import bram_capture_writer_pkg::*;
#(
   parameter int WORD_WID      = 24,
   parameter int WORD_AMNT_WID = 11,
   parameter int WORD_AMNT     = 2047,
   parameter int RAM_WID       = DEF_RAM_WID,
   parameter int RAM_WORD_WID  = DEF_RAM_WORD_WID,
   parameter int RAM_WORD_INCR = DEF_RAM_WORD_INCR
) (
   input  logic                     clk,
   input  logic                     rst_L,
   input  logic [WORD_WID-1:0]      word,
   input  logic                     word_push,
   output logic                     word_ok,
   input  logic                     word_rst,
   output logic                     full,
   output logic [WORD_AMNT_WID:0]   word_cnt,
   input  logic                     flush_start,
   input  logic [RAM_WID-1:0]       start_addr,
   output logic                     flush_finished,
   output logic [RAM_WID-1:0]       ram_dma_addr,
   output logic [RAM_WORD_WID-1:0]  ram_word,
   output logic                     ram_write,
   input  logic                     ram_valid
);

   localparam logic [WORD_AMNT_WID:0] CAPACITY = (WORD_AMNT_WID+1)'(WORD_AMNT + 1);
   localparam logic [WORD_AMNT_WID:0] CNT_ONE  = (WORD_AMNT_WID+1)'(1);
   localparam logic [RAM_WID-1:0]     ADDR_INC = RAM_WID'(RAM_WORD_INCR);
   localparam int                     HI_WID   = WORD_WID - RAM_WORD_WID;

   flush_state_e              state_q, state_d;
   logic                      word_ok_q, word_ok_d;
   logic [WORD_AMNT_WID:0]    word_cnt_q, word_cnt_d;
   logic [WORD_AMNT_WID-1:0]  idx_q, idx_d;
   logic [RAM_WID-1:0]        addr_q, addr_d;
   logic [RAM_WORD_WID-1:0]   ram_word_q, ram_word_d;
   logic                      ram_write_q, ram_write_d;
   logic                      finished_q, finished_d;

   logic                      buf_wr_en;
   logic [WORD_WID-1:0]       rd_dat_q;
   logic                      flush_launch;
   logic                      last_word;

   // A pending push handshake must finish before a flush may start.
   assign flush_launch = (state_q == ST_IDLE) && flush_start && !word_ok_q;
   // Compared against the index before it advances past the final word.
   assign last_word    = ({1'b0, idx_q} == (word_cnt_q - CNT_ONE));

   // Read address follows the next index so the registered read is ready
   // the cycle the DMA request is raised.
   bram_capture_writer_capture_buffer #(
      .DAT_WID  (WORD_WID),
      .ADDR_WID (WORD_AMNT_WID),
      .DEPTH    (WORD_AMNT + 1)
   ) u_buf (
      .clk      (clk),
      .wr_en    (buf_wr_en),
      .wr_addr  (word_cnt_q[WORD_AMNT_WID-1:0]),
      .wr_dat   (word),
      .rd_addr  (idx_d),
      .rd_dat_q (rd_dat_q)
   );

   // State register and all control/data flops.
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state_q     <= ST_IDLE;
         word_ok_q   <= 1'b0;
         word_cnt_q  <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         ram_word_q  <= '0;
         ram_write_q <= 1'b0;
         finished_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_ok_q   <= word_ok_d;
         word_cnt_q  <= word_cnt_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         ram_word_q  <= ram_word_d;
         ram_write_q <= ram_write_d;
         finished_q  <= finished_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_launch) begin
               state_d = (word_cnt_q == '0) ? ST_WAIT_DEASSERT : ST_WRITE_LOW;
            end
         end
         ST_WRITE_LOW: begin
            if (ram_write_q && ram_valid) state_d = ST_WRITE_HIGH;
         end
         ST_WRITE_HIGH: begin
            if (ram_write_q && ram_valid) begin
               state_d = last_word ? ST_WAIT_DEASSERT : ST_WRITE_LOW;
            end
         end
         ST_WAIT_DEASSERT: begin
            if (!flush_start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      word_ok_d   = word_ok_q;
      word_cnt_d  = word_cnt_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      ram_word_d  = ram_word_q;
      ram_write_d = ram_write_q;
      finished_d  = finished_q;
      buf_wr_en   = 1'b0;

      if (!word_push && word_ok_q) word_ok_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (flush_launch) begin
               addr_d = start_addr;
               idx_d  = '0;
            end else begin
               if (word_push && !word_ok_q && !full) begin
                  word_ok_d = 1'b1;
                  // word_rst wins: the handshake completes but nothing is stored.
                  if (!word_rst) begin
                     buf_wr_en  = 1'b1;
                     word_cnt_d = word_cnt_q + CNT_ONE;
                  end
               end
               if (word_rst) word_cnt_d = '0;
            end
         end
         ST_WRITE_LOW: begin
            if (!ram_write_q) begin
               ram_word_d  = rd_dat_q[RAM_WORD_WID-1:0];
               ram_write_d = 1'b1;
            end else if (ram_valid) begin
               ram_write_d = 1'b0;
               addr_d      = addr_q + ADDR_INC;
            end
         end
         ST_WRITE_HIGH: begin
            if (!ram_write_q) begin
               ram_word_d  = {{(RAM_WORD_WID-HI_WID){1'b0}}, rd_dat_q[WORD_WID-1:RAM_WORD_WID]};
               ram_write_d = 1'b1;
            end else if (ram_valid) begin
               ram_write_d = 1'b0;
               addr_d      = addr_q + ADDR_INC;
               idx_d       = idx_q + 1'b1;
            end
         end
         ST_WAIT_DEASSERT: begin
            finished_d = flush_start;
            if (!flush_start) word_cnt_d = '0;
         end
         default: ;
      endcase
   end

   assign word_ok        = word_ok_q;
   assign word_cnt       = word_cnt_q;
   assign full           = (word_cnt_q == CAPACITY);
   assign flush_finished = finished_q;
   assign ram_dma_addr   = addr_q;
   assign ram_word       = ram_word_q;
   assign ram_write      = ram_write_q;

endmodule

// File: tb/tb_bram_capture_writer.sv
// Purpose: self-checking bench for bram_capture_writer with a small four-word buffer.
// Latency: responder acknowledges each DMA request two cycles after it appears.
// Backpressure: DMA writes are checked by a scoreboard monitor against queued expectations.
module tb_bram_capture_writer;

   localparam int WW  = 24;
   localparam int AW  = 2;
   localparam int RW  = 32;
   localparam int RWW = 16;

   typedef struct {
      logic [RW-1:0]  addr;
      logic [RWW-1:0] dat;
   } dma_t;

   logic            clk = 1'b0;
   logic            rst_L;
   logic [WW-1:0]   word;
   logic            word_push;
   logic            word_ok;
   logic            word_rst;
   logic            full;
   logic [AW:0]     word_cnt;
   logic            flush_start;
   logic [RW-1:0]   start_addr;
   logic            flush_finished;
   logic [RW-1:0]   ram_dma_addr;
   logic [RWW-1:0]  ram_word;
   logic            ram_write;
   logic            ram_valid;

   int   n_chk = 0;
   int   n_err = 0;
   dma_t exp_q[$];
   bit   prev_write = 1'b0;

   bram_capture_writer #(
      .WORD_WID      (WW),
      .WORD_AMNT_WID (AW),
      .WORD_AMNT     (3),
      .RAM_WID       (RW),
      .RAM_WORD_WID  (RWW),
      .RAM_WORD_INCR (2)
   ) dut (
      .clk            (clk),
      .rst_L          (rst_L),
      .word           (word),
      .word_push      (word_push),
      .word_ok        (word_ok),
      .word_rst       (word_rst),
      .full           (full),
      .word_cnt       (word_cnt),
      .flush_start    (flush_start),
      .start_addr     (start_addr),
      .flush_finished (flush_finished),
      .ram_dma_addr   (ram_dma_addr),
      .ram_word       (ram_word),
      .ram_write      (ram_write),
      .ram_valid      (ram_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected DMA pair for one captured word: low half, then zero-extended high half.
   task automatic expect_word(input logic [RW-1:0] base, input logic [WW-1:0] w);
      dma_t e;
      e.addr = base;
      e.dat  = w[15:0];
      exp_q.push_back(e);
      e.addr = base + 32'd2;
      e.dat  = {8'h00, w[23:16]};
      exp_q.push_back(e);
   endtask

   task automatic push(input logic [WW-1:0] w, input string name);
      word      = w;
      word_push = 1'b1;
      tick();
      chk({name, "_ok_lat"}, word_ok, 1);
      word_push = 1'b0;
      tick();
      chk({name, "_ok_drop"}, word_ok, 0);
   endtask

   task automatic do_flush(input logic [RW-1:0] base, input string name);
      int n;
      start_addr  = base;
      flush_start = 1'b1;
      n = 0;
      while (!flush_finished && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_finished"}, flush_finished, 1);
      chk({name, "_all_dma_seen"}, exp_q.size(), 0);
      flush_start = 1'b0;
      tick();
      chk({name, "_finished_drop"}, flush_finished, 0);
      chk({name, "_cnt_cleared"}, word_cnt, 0);
   endtask

   // DMA responder: acknowledge each request two cycles after it is seen.
   initial begin
      ram_valid = 1'b0;
      forever begin
         tick();
         if (ram_write) begin
            tick();
            ram_valid = 1'b1;
            tick();
            ram_valid = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every new DMA request is compared against the queue head.
   initial begin
      dma_t e;
      forever begin
         @(negedge clk);
         if (ram_write && !prev_write) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL dma_unexpected: addr 0x%0h data 0x%0h, expected no write", ram_dma_addr, ram_word);
            end else begin
               e = exp_q.pop_front();
               chk("dma_addr", ram_dma_addr, e.addr);
               chk("dma_data", ram_word, e.dat);
            end
         end
         prev_write = ram_write;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [WW-1:0] fill [4];
      fill[0] = 24'h111111;
      fill[1] = 24'h222222;
      fill[2] = 24'h333333;
      fill[3] = 24'h444444;

      rst_L       = 1'b0;
      word        = '0;
      word_push   = 1'b0;
      word_rst    = 1'b0;
      flush_start = 1'b0;
      start_addr  = '0;
      repeat (3) tick();
      chk("rst_word_ok", word_ok, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_full", full, 0);
      chk("rst_finished", flush_finished, 0);
      chk("rst_ram_write", ram_write, 0);
      chk("rst_ram_addr", ram_dma_addr, 0);
      chk("rst_ram_word", ram_word, 0);
      rst_L = 1'b1;
      tick();

      // Two words, flushed with a two-cycle responder.
      push(24'h123456, "p1");
      push(24'hABCDEF, "p2");
      chk("two_cnt", word_cnt, 2);
      chk("two_full", full, 0);
      expect_word(32'h1000, 24'h123456);
      expect_word(32'h1004, 24'hABCDEF);
      do_flush(32'h1000, "fl2");

      // Fill to capacity; the fifth push stalls until the flush empties the buffer.
      for (int i = 0; i < 4; i++) push(fill[i], "fill");
      chk("fill_cnt", word_cnt, 4);
      chk("fill_full", full, 1);
      word      = 24'h555555;
      word_push = 1'b1;
      repeat (3) tick();
      chk("stall_ok", word_ok, 0);
      chk("stall_cnt", word_cnt, 4);
      for (int i = 0; i < 4; i++) expect_word(32'h2000 + 32'(i * 4), fill[i]);
      do_flush(32'h2000, "fl4");
      chk("stall_ok_after_flush", word_ok, 0);
      tick();
      chk("stall_acked", word_ok, 1);
      chk("stall_cnt1", word_cnt, 1);
      word_push = 1'b0;
      tick();
      expect_word(32'h3000, 24'h555555);
      do_flush(32'h3000, "fl1");

      // Empty flush: no DMA traffic, finished one cycle after entering the wait state.
      flush_start = 1'b1;
      tick();
      chk("empty_fin_early", flush_finished, 0);
      tick();
      chk("empty_fin", flush_finished, 1);
      chk("empty_no_write", ram_write, 0);
      flush_start = 1'b0;
      tick();
      chk("empty_fin_drop", flush_finished, 0);

      // Reset while the high half is being written.
      push(24'h0A0B0C, "p_rst");
      expect_word(32'h4000, 24'h0A0B0C);
      start_addr  = 32'h4000;
      flush_start = 1'b1;
      n = 0;
      while (!(ram_write && ram_word == 16'h000A) && n < 100) begin
         tick();
         n++;
      end
      chk("rst_mid_reached_high", ram_write && ram_word == 16'h000A, 1);
      rst_L = 1'b0;
      tick();
      chk("rst_mid_write", ram_write, 0);
      chk("rst_mid_fin", flush_finished, 0);
      chk("rst_mid_cnt", word_cnt, 0);
      rst_L       = 1'b1;
      flush_start = 1'b0;
      repeat (5) tick();
      chk("rst_mid_idle_write", ram_write, 0);
      chk("rst_mid_queue", exp_q.size(), 0);

      // word_rst beats a same-cycle push; the handshake still completes.
      push(24'h777777, "p_pre");
      chk("pre_rst_cnt", word_cnt, 1);
      word      = 24'h999999;
      word_push = 1'b1;
      word_rst  = 1'b1;
      tick();
      chk("wrst_ok", word_ok, 1);
      chk("wrst_cnt", word_cnt, 0);
      word_rst  = 1'b0;
      word_push = 1'b0;
      tick();
      chk("wrst_ok_drop", word_ok, 0);
      chk("wrst_cnt_hold", word_cnt, 0);

      // Address wraps past the top of the DMA space.
      push(24'h121212, "p_wrap");
      exp_q.push_back('{addr: 32'hFFFF_FFFE, dat: 16'h1212});
      exp_q.push_back('{addr: 32'h0000_0000, dat: 16'h0012});
      do_flush(32'hFFFF_FFFE, "flwrap");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bram_capture_writer.md
Name: bram_capture_writer

Overview:
Write-direction counterpart of the autoapproach word reader. Accepts WORD_WID-bit words from a producer (sweep or sample recorder) over a four-phase push/ok handshake and stores them in a local backing buffer. On user request, drains the buffer to RAM over the DMA write port, one RAM_WORD_WID half-word per transfer, low half first. RAM is the downstream responder; this block is the initiator.

Parameters:
WORD_WID, 24, captured word width; must satisfy RAM_WORD_WID < WORD_WID <= 2*RAM_WORD_WID
WORD_AMNT_WID, 11, width of buffer index
WORD_AMNT, 2047, last valid buffer INDEX (capacity = WORD_AMNT+1)
RAM_WID, 32, DMA address width
RAM_WORD_WID, 16, DMA data width
RAM_WORD_INCR, 2, address increment per DMA transfer

Ports:
clk  in  1  system clock
rst_L  in  1  reset, synchronous, active-low
word  in  WORD_WID  producer data, stable while word_push high
word_push  in  1  producer request
word_ok  out  1  capture acknowledge
word_rst  in  1  discard buffer contents (count := 0)
full  out  1  buffer holds WORD_AMNT+1 words
word_cnt  out  WORD_AMNT_WID+1  words currently held
flush_start  in  1  user flush request, level, held until flush_finished
start_addr  in  RAM_WID  RAM base address, sampled when flush starts
flush_finished  out  1  flush complete; held until flush_start drops
ram_dma_addr  out  RAM_WID  DMA address
ram_word  out  RAM_WORD_WID  DMA write data
ram_write  out  1  DMA write request
ram_valid  in  1  DMA write acknowledge

Behaviour:
- Reset (rst_L=0 at posedge): all outputs 0, word_cnt 0, state IDLE, rd index 0. Buffer contents undefined. Reset mid-flush aborts immediately; ram_write drops next cycle.
- Capture (only in IDLE): if word_push && !word_ok && !full -> buffer[word_cnt] <= word, word_cnt++, word_ok <= 1 (latency 1 cycle). If !word_push && word_ok -> word_ok <= 0. While full or not IDLE, push stalls (word_ok stays 0, nothing written). full is combinational from word_cnt == WORD_AMNT+1.
- word_rst (IDLE only; ignored otherwise): word_cnt <= 0, takes priority over a same-cycle push; word_ok still completes its handshake normally.
- Flush FSM, states IDLE, WRITE_LOW, WRITE_HIGH, WAIT_DEASSERT:
  IDLE: flush_start && !word_ok -> ram_dma_addr <= start_addr, rd index <= 0; if word_cnt==0 go WAIT_DEASSERT else WRITE_LOW. A pending push handshake (word_ok=1) completes first.
  WRITE_LOW: if !ram_write -> ram_word <= buffer[idx][RAM_WORD_WID-1:0], ram_write <= 1. Else if ram_valid -> ram_write <= 0, addr += RAM_WORD_INCR, go WRITE_HIGH.
  WRITE_HIGH: same handshake, ram_word <= zero-extended buffer[idx][WORD_WID-1:RAM_WORD_WID]. On ram_valid: addr += RAM_WORD_INCR, idx++; if idx == word_cnt-1 go WAIT_DEASSERT else WRITE_LOW.
  WAIT_DEASSERT: flush_finished <= 1 while flush_start high; when flush_start low -> flush_finished <= 0, word_cnt <= 0, go IDLE.
- ram_write and ram_word/ram_dma_addr stable from request until ram_valid; ram_write low for at least one cycle between transfers. ram_valid outside a request ignored.
- Address arithmetic wraps modulo 2^RAM_WID.
- flush_start dropped early (mid-transfer) is ignored until WAIT_DEASSERT.
- Buffer read is registered-friendly (one-cycle read into ram_word), inferable as block RAM.

Decomposition:
- Shared package: FSM state encodings, default DMA widths/increment shared with the reader block.
- Natural sub-module: capture_buffer (simple dual-port RAM, one write port, one registered read port).

Test Plan:
- Bench params WORD_AMNT=3. Push 0x123456, 0xABCDEF -> word_ok per push 1 cycle after word_push, word_cnt=2, full=0.
- Flush at start_addr=0x1000, responder acks after 2 cycles -> writes (0x1000,0x3456),(0x1002,0x0012),(0x1004,0xCDEF),(0x1006,0x00AB); flush_finished=1; on flush_start low, word_cnt=0.
- Push 5 words -> first 4 acked, full=1, 5th word_ok stays 0 until flush completes, then acked into index 0.
- Flush with word_cnt=0 -> no ram_write, flush_finished next cycle after WAIT_DEASSERT entry.
- rst_L=0 during WRITE_HIGH -> next cycle ram_write=0, flush_finished=0, word_cnt=0, state IDLE.
- word_rst with word_push same cycle in IDLE -> word_cnt=0, handshake completes, no write stored.
